leitor_sete_segmentos: RTL and testbench
========================================

LEITOR_SETE_SEGMENTOS -- requirements
Module: leitor_sete_segmentos

Interface
REQ-001 Parameter ESTAVEL, default 2: consecutive identical frames required before the output updates (legal range 1..15).
REQ-002 Parameter TIMEOUT, default 4096: clock cycles without a legal digit enable before the bus is declared inactive (used only with LEITOR_TIMEOUT_EN).
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 segmentos  input  7  display segment lines, active-low; bit6=a ... bit0=g.
REQ-006 anodos  input  4  digit enables, active-low; bit i low selects digit i.
REQ-007 digitos  output  16  decoded frame; digitos[4i+3:4i] = digit i code.
REQ-008 valido  output  1  one-cycle pulse when digitos updates.
REQ-009 erro  output  1  frame most recently closed held an unrecognised pattern.
REQ-010 inativo  output  1  bus inactive (timeout).

Function
REQ-011 segmentos and anodos SHALL be registered once before use; all latencies below count from that registered sample.
REQ-012 Legal enable: exactly one anodos bit low. Zero or more than one bit low SHALL be ignored (no capture, no frame event).
REQ-013 Pattern map (active-low): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1111111->4'hF (blank); any other pattern->4'hE (invalid).
REQ-014 While digit i is legally enabled, shadow[i] SHALL load the decoded code every cycle (last sample wins), and seen[i] SHALL be set.
REQ-015 FSM states: OCIOSO, CAPTURA, FECHA. Reset enters OCIOSO.
REQ-016 OCIOSO -> CAPTURA on the first legal enable of digit 0; captures before that are discarded.
REQ-017 CAPTURA -> FECHA when seen==4'b1111 and a legal enable of digit 0 arrives after a legal enable of a different digit; that cycle's digit-0 sample belongs to the next frame (seen restarts as 4'b0001).
REQ-018 FECHA lasts exactly one cycle, then returns to CAPTURA; capture continues during FECHA.
REQ-019 In FECHA: if shadow equals candidate, count increments (saturating at ESTAVEL); else candidate<=shadow, count<=1.
REQ-020 When count reaches ESTAVEL exactly (first time for that candidate): digitos<=candidate and valido=1 for one cycle (the cycle after FECHA); no re-pulse while count is saturated.
REQ-021 erro SHALL update in every FECHA: 1 if any shadow code is 4'hE, else 0; independent of ESTAVEL.
REQ-022 A missing digit in a round (seen != 4'b1111 at the digit-0 wrap) SHALL discard the round without FECHA, reset seen to 4'b0001, and leave count unchanged.

Reset
REQ-023 reset low SHALL asynchronously force: digitos=16'hFFFF, valido=0, erro=0, inativo=0, state=OCIOSO, seen=0, count=0, candidate=16'hFFFF, shadow=16'hFFFF, timeout counter=0.
REQ-024 Reset mid-frame SHALL discard all partial captures; after release, behaviour matches power-up.

Configuration
REQ-025 Macro LEITOR_TIMEOUT_EN defined: a counter clears on every legal enable and increments otherwise; at TIMEOUT it sets inativo=1, forces OCIOSO, clears seen and count; inativo clears on the next legal enable.
REQ-026 Macro undefined: no timeout counter; inativo SHALL be tied to 0.

Verification
REQ-027 Scan digits 0..3 with patterns for 1,2,3,4 (4 cycles each), three rounds, ESTAVEL=2 -> digitos=16'h4321, exactly one valido pulse, erro=0.
REQ-028 Digit 2 pattern 1111110 for one round -> erro=1 after that FECHA; digit 2 code 4'hE; digitos unchanged until two identical frames.
REQ-029 anodos=4'b0000 and 4'b1100 injected mid-round -> ignored; decoded value unaffected.
REQ-030 Alternate frames 1234 / 5678 -> count never reaches 2; no valido, digitos stays 16'hFFFF.
REQ-031 Assert reset during digit 2 of a frame -> all outputs at reset values asynchronously; next stable value needs ESTAVEL fresh frames.
REQ-032 With LEITOR_TIMEOUT_EN, TIMEOUT=16: hold anodos=4'b1111 for 16 cycles -> inativo=1; one legal enable -> inativo=0, FSM in OCIOSO/CAPTURA.

Source files
------------

// File: rtl/leitor_sete_segmentos_if.sv
// Seven-segment bus tap: multiplexed display lines in, decoded frame and status out.
interface leitor_sete_segmentos_if;
   logic [6:0]  segmentos;
   logic [3:0]  anodos;
   logic [15:0] digitos;
   logic        valido;
   logic        erro;
   logic        inativo;

   modport master (output segmentos, anodos, input digitos, valido, erro, inativo);
   modport slave  (input segmentos, anodos, output digitos, valido, erro, inativo);
endinterface

// File: rtl/leitor_sete_segmentos.sv
// Seven-segment display reader: decodes a scanned 4-digit display into a stable 16-bit frame.
// Optional bus-inactivity timeout enabled by defining LEITOR_TIMEOUT_EN.
//
// state   | meaning
// OCIOSO  | waiting for the first digit-0 enable to align to a frame
// CAPTURA | collecting digits into shadow until the digit-0 wrap
// FECHA   | one cycle: compare closed frame with candidate, update outputs
module leitor_sete_segmentos #(
   parameter int ESTAVEL = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic                    clock,
   input  logic                    reset,
   leitor_sete_segmentos_if.slave  bus
);

   typedef enum logic [1:0] {OCIOSO, CAPTURA, FECHA} estado_t;

   function automatic logic [3:0] decode(input logic [6:0] s);
      case (s)
         7'b0000001: decode = 4'h0;
         7'b1001111: decode = 4'h1;
         7'b0010010: decode = 4'h2;
         7'b0000110: decode = 4'h3;
         7'b1001100: decode = 4'h4;
         7'b0100100: decode = 4'h5;
         7'b0100000: decode = 4'h6;
         7'b0001111: decode = 4'h7;
         7'b0000000: decode = 4'h8;
         7'b0000100: decode = 4'h9;
         7'b1111111: decode = 4'hF;
         default:    decode = 4'hE;
      endcase
   endfunction

   logic [6:0]  seg_q;
   logic [3:0]  an_q;
   estado_t     estado_q, estado_d;
   logic [3:0]  seen_q, seen_d;
   logic [1:0]  last_dig_q, last_dig_d;
   logic [15:0] shadow_q, shadow_d;
   logic [15:0] snap_q, snap_d;
   logic [15:0] cand_q, cand_d;
   logic [3:0]  count_q, count_d;
   logic [15:0] digitos_q, digitos_d;
   logic        valido_q, valido_d;
   logic        erro_q, erro_d;
   logic        inativo_q, inativo_d;

   logic        legal;
   logic [1:0]  idx;
   logic [3:0]  code;
   logic        wrap;

`ifdef LEITOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

   always_comb begin
      legal = 1'b1;
      idx   = 2'd0;
      case (an_q)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: legal = 1'b0;
      endcase
      code = decode(seg_q);
      // a frame boundary is a digit-0 enable that follows some other digit
      wrap = legal && (idx == 2'd0) && (last_dig_q != 2'd0);

      estado_d   = estado_q;
      seen_d     = seen_q;
      last_dig_d = legal ? idx : last_dig_q;
      shadow_d   = shadow_q;
      snap_d     = snap_q;
      cand_d     = cand_q;
      count_d    = count_q;
      digitos_d  = digitos_q;
      valido_d   = 1'b0;
      erro_d     = erro_q;
      inativo_d  = inativo_q;

      case (estado_q)
         OCIOSO: begin
            if (legal && idx == 2'd0) begin
               estado_d      = CAPTURA;
               seen_d        = 4'b0001;
               shadow_d[3:0] = code;
            end
         end
         CAPTURA: begin
            if (wrap) begin
               seen_d        = 4'b0001;
               shadow_d[3:0] = code;
               snap_d        = shadow_q;
               if (seen_q == 4'b1111) estado_d = FECHA;
            end else if (legal) begin
               seen_d[idx]                = 1'b1;
               shadow_d[{idx, 2'b00} +: 4] = code;
            end
         end
         default: begin
            estado_d = CAPTURA;
            if (legal) begin
               seen_d[idx]                = 1'b1;
               shadow_d[{idx, 2'b00} +: 4] = code;
            end
            erro_d = 1'b0;
            for (int i = 0; i < 4; i++)
               if (snap_q[4*i +: 4] == 4'hE) erro_d = 1'b1;
            if (snap_q == cand_q) begin
               if (count_q < 4'(ESTAVEL)) begin
                  count_d = count_q + 4'd1;
                  if (count_q + 4'd1 == 4'(ESTAVEL)) begin
                     digitos_d = snap_q;
                     valido_d  = 1'b1;
                  end
               end
            end else begin
               cand_d  = snap_q;
               count_d = 4'd1;
               if (ESTAVEL == 1) begin
                  digitos_d = snap_q;
                  valido_d  = 1'b1;
               end
            end
         end
      endcase

`ifdef LEITOR_TIMEOUT_EN
      to_cnt_d = to_cnt_q;
      if (legal) begin
         to_cnt_d  = '0;
         inativo_d = 1'b0;
      end else if (to_cnt_q < TW'(TIMEOUT)) begin
         to_cnt_d = to_cnt_q + 1'b1;
         if (to_cnt_q + 1'b1 == TW'(TIMEOUT)) begin
            inativo_d = 1'b1;
            estado_d  = OCIOSO;
            seen_d    = 4'b0000;
            count_d   = 4'd0;
         end
      end
`else
      inativo_d = 1'b0;
`endif
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         seg_q      <= 7'h7F;
         an_q       <= 4'hF;
         estado_q   <= OCIOSO;
         seen_q     <= 4'b0000;
         last_dig_q <= 2'd0;
         shadow_q   <= 16'hFFFF;
         snap_q     <= 16'hFFFF;
         cand_q     <= 16'hFFFF;
         count_q    <= 4'd0;
         digitos_q  <= 16'hFFFF;
         valido_q   <= 1'b0;
         erro_q     <= 1'b0;
         inativo_q  <= 1'b0;
`ifdef LEITOR_TIMEOUT_EN
         to_cnt_q   <= '0;
`endif
      end else begin
         seg_q      <= bus.segmentos;
         an_q       <= bus.anodos;
         estado_q   <= estado_d;
         seen_q     <= seen_d;
         last_dig_q <= last_dig_d;
         shadow_q   <= shadow_d;
         snap_q     <= snap_d;
         cand_q     <= cand_d;
         count_q    <= count_d;
         digitos_q  <= digitos_d;
         valido_q   <= valido_d;
         erro_q     <= erro_d;
         inativo_q  <= inativo_d;
`ifdef LEITOR_TIMEOUT_EN
         to_cnt_q   <= to_cnt_d;
`endif
      end
   end

   assign bus.digitos = digitos_q;
   assign bus.valido  = valido_q;
   assign bus.erro    = erro_q;
   assign bus.inativo = inativo_q;

endmodule

// File: tb/tb_leitor_sete_segmentos.sv
// Bench for leitor_sete_segmentos: decode table sweep plus multi-frame corner sequences.
module tb_leitor_sete_segmentos;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   leitor_sete_segmentos_if bus ();

   leitor_sete_segmentos #(
      .ESTAVEL (2),
      .TIMEOUT (16)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   localparam logic [6:0] P0 = 7'b0000001, P1 = 7'b1001111, P2 = 7'b0010010, P3 = 7'b0000110;
   localparam logic [6:0] P4 = 7'b1001100, P5 = 7'b0100100, P6 = 7'b0100000, P7 = 7'b0001111;
   localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0000100, PB = 7'b1111111, PX = 7'b1111110;

   typedef struct {logic [6:0] seg; logic [3:0] code;} vec_t;
   typedef struct {logic [15:0] dig; logic err;} exp_t;

   vec_t tab [12];
   exp_t sb [$];
   int   checks = 0;
   int   passed = 0;
   int   pulses = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, req);
   endtask

   // scoreboard: every valido pulse must match the oldest pending expectation
   always @(negedge clock) begin
      if (reset && bus.valido === 1'b1) begin
         pulses++;
         if (sb.size() == 0) begin
            checks++;
            $display("FAIL valido_unexpected: digitos=%h, expected no pulse", bus.digitos);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pulse_digitos", bus.digitos, e.dig);
            check("pulse_erro", bus.erro, e.err);
         end
      end
   end

   task automatic drive_digit(input int d, input logic [6:0] seg, input int n);
      bus.segmentos = seg;
      bus.anodos    = ~(4'b0001 << d);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic frame(input logic [6:0] s0, s1, s2, s3, input int n);
      drive_digit(0, s0, n);
      drive_digit(1, s1, n);
      drive_digit(2, s2, n);
      drive_digit(3, s3, n);
   endtask

   task automatic do_reset();
      bus.anodos    = 4'hF;
      bus.segmentos = PB;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int p0;
      exp_t e;
      tab[0]  = '{P0, 4'h0}; tab[1]  = '{P1, 4'h1}; tab[2]  = '{P2, 4'h2}; tab[3]  = '{P3, 4'h3};
      tab[4]  = '{P4, 4'h4}; tab[5]  = '{P5, 4'h5}; tab[6]  = '{P6, 4'h6}; tab[7]  = '{P7, 4'h7};
      tab[8]  = '{P8, 4'h8}; tab[9]  = '{P9, 4'h9}; tab[10] = '{PB, 4'hF}; tab[11] = '{PX, 4'hE};

      bus.segmentos = PB;
      bus.anodos    = 4'hF;
      #12;
      check("reset_digitos", bus.digitos, 16'hFFFF);
      check("reset_valido", bus.valido, 1'b0);
      check("reset_erro", bus.erro, 1'b0);
      check("reset_inativo", bus.inativo, 1'b0);
      do_reset();

      // decode sweep: each rotated frame shown twice, so it becomes stable once
      p0 = pulses;
      for (int k = 0; k < 12; k++) begin
         for (int r = 0; r < 2; r++) begin
            if (r == 1) begin
               e.dig = {tab[(k+3)%12].code, tab[(k+2)%12].code, tab[(k+1)%12].code, tab[k].code};
               e.err = (k >= 8);
               sb.push_back(e);
            end
            frame(tab[k].seg, tab[(k+1)%12].seg, tab[(k+2)%12].seg, tab[(k+3)%12].seg, 2);
         end
      end
      drive_digit(0, tab[0].seg, 4);
      check("table_pulses", pulses - p0, 12);
      check("table_queue_empty", sb.size(), 0);

      // three identical 1234 rounds: one pulse
      do_reset();
      p0 = pulses;
      sb.push_back('{16'h4321, 1'b0});
      repeat (3) frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("stable_digitos", bus.digitos, 16'h4321);
      check("stable_erro", bus.erro, 1'b0);
      check("stable_pulses", pulses - p0, 1);

      // bad digit 2: erro immediately, digitos only after two identical frames
      frame(P1, P2, PX, P4, 4);
      drive_digit(0, P1, 4);
      check("bad_erro", bus.erro, 1'b1);
      check("bad_digitos_held", bus.digitos, 16'h4321);
      sb.push_back('{16'h4E21, 1'b1});
      frame(P1, P2, PX, P4, 4);
      drive_digit(0, P1, 4);
      check("bad_digitos_stable", bus.digitos, 16'h4E21);
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("bad_erro_cleared", bus.erro, 1'b0);
      check("bad_queue_empty", sb.size(), 0);

      // illegal enable patterns injected mid-round
      do_reset();
      p0 = pulses;
      sb.push_back('{16'h4321, 1'b0});
      repeat (3) begin
         drive_digit(0, P1, 4);
         drive_digit(1, P2, 4);
         bus.segmentos = P8; bus.anodos = 4'b0000;
         repeat (3) @(posedge clock);
         #1 bus.anodos = 4'b1100;
         repeat (3) @(posedge clock);
         #1;
         drive_digit(2, P3, 4);
         drive_digit(3, P4, 4);
      end
      drive_digit(0, P1, 4);
      check("illegal_digitos", bus.digitos, 16'h4321);
      check("illegal_pulses", pulses - p0, 1);

      // incomplete round is discarded without disturbing count
      do_reset();
      p0 = pulses;
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P5, 4);
      drive_digit(1, P6, 4);
      drive_digit(2, P7, 4);
      sb.push_back('{16'h4321, 1'b0});
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("missing_digitos", bus.digitos, 16'h4321);
      check("missing_pulses", pulses - p0, 1);

      // alternating frames never stabilise
      do_reset();
      p0 = pulses;
      repeat (3) begin
         frame(P1, P2, P3, P4, 3);
         frame(P5, P6, P7, P8, 3);
      end
      drive_digit(0, P1, 4);
      check("alt_pulses", pulses - p0, 0);
      check("alt_digitos", bus.digitos, 16'hFFFF);

      // asynchronous reset during digit 2
      do_reset();
      sb.push_back('{16'h4321, 1'b0});
      repeat (3) frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      drive_digit(1, P2, 4);
      check("pre_reset_digitos", bus.digitos, 16'h4321);
      bus.segmentos = P3; bus.anodos = 4'b1011;
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_digitos", bus.digitos, 16'hFFFF);
      check("async_valido", bus.valido, 1'b0);
      check("async_erro", bus.erro, 1'b0);
      check("async_inativo", bus.inativo, 1'b0);
      @(posedge clock);
      #1 reset = 1'b1;
      p0 = pulses;
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("post_reset_no_pulse", pulses - p0, 0);
      sb.push_back('{16'h4321, 1'b0});
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("post_reset_pulse", pulses - p0, 1);
      check("post_reset_digitos", bus.digitos, 16'h4321);

      // bus inactivity
      bus.anodos = 4'hF;
      repeat (20) @(posedge clock);
      #1;
`ifdef LEITOR_TIMEOUT_EN
      check("timeout_inativo_set", bus.inativo, 1'b1);
      drive_digit(0, P1, 3);
      check("timeout_inativo_clear", bus.inativo, 1'b0);
      p0 = pulses;
      drive_digit(1, P2, 4);
      drive_digit(2, P3, 4);
      drive_digit(3, P4, 4);
      sb.push_back('{16'h4321, 1'b0});
      frame(P1, P2, P3, P4, 4);
      drive_digit(0, P1, 4);
      check("timeout_recovery_pulse", pulses - p0, 1);
`else
      check("no_timeout_inativo", bus.inativo, 1'b0);
`endif
      check("final_queue_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
